usbfs_in_arb: RTL and testbench

- Sequences the shared USB full-speed packet transmitter across N_ENDP IN endpoints.
- On each IN token it does three things:
  - selects the addressed endpoint;
  - decides the response PID: DATA0, DATA1, NAK or STALL;
  - drives the transmitter handshake.
- After a data packet it waits for the host ACK. Only on ACK does it signal the endpoint to release its buffered packet and toggle its data PID.
- Sits between the token decoder, the per-endpoint TX buffers and the transmitter.

---
 rtl/usbfs_pkg.sv | 24 ++
 rtl/usbfs_toggle_bank.sv | 37 +++
 rtl/usbfs_in_arb.sv | 150 +++++++++++++++
 tb/tb_usbfs_in_arb.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/usbfs_pkg.sv
// Shared encodings for the USB full-speed IN-endpoint arbiter.
package usbfs_pkg;

  localparam int unsigned EP_W = 4;

  typedef enum logic [1:0] {
    PID_DATA0 = 2'd0,
    PID_DATA1 = 2'd1,
    PID_NAK   = 2'd2,
    PID_STALL = 2'd3
  } pid_t;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_REQ      = 2'd1,
    ST_TX       = 2'd2,
    ST_WAIT_ACK = 2'd3
  } state_t;

  function automatic pid_t data_pid(input logic tog);
    return tog ? PID_DATA1 : PID_DATA0;
  endfunction

endpackage

// File: rtl/usbfs_toggle_bank.sv
// Per-endpoint DATA0/DATA1 toggle flops; a SETUP forces 1 and outranks an ACK invert.
module usbfs_toggle_bank
  import usbfs_pkg::*;
#(
  parameter int unsigned N_ENDP = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ack,
  input  logic [EP_W-1:0]   ack_endp,
  input  logic              setup,
  input  logic [EP_W-1:0]   setup_endp,
  output logic [N_ENDP-1:0] toggle
);

  logic [N_ENDP-1:0] toggle_d;

  always_comb begin
    toggle_d = toggle;
    for (int i = 0; i < int'(N_ENDP); i++) begin
      if (setup && (setup_endp == EP_W'(i))) begin
        toggle_d[i] = 1'b1;
      end else if (ack && (ack_endp == EP_W'(i))) begin
        toggle_d[i] = ~toggle[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      toggle <= '0;
    end else begin
      toggle <= toggle_d;
    end
  end

endmodule

// File: rtl/usbfs_in_arb.sv
// IN-token sequencer for the shared USB FS transmitter: picks endpoint and PID, waits for ACK.
// Define USBFS_IN_ARB_TIMEOUT_EN to use an internal ACK_TIMEOUT counter instead of i_ackTimeout.
module usbfs_in_arb
  import usbfs_pkg::*;
#(
  parameter int unsigned N_ENDP      = 4,
  parameter int unsigned ACK_TIMEOUT = 18
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic              i_tokValid,
  input  logic [EP_W-1:0]   i_tokEndp,
  input  logic              i_setupValid,
  input  logic [EP_W-1:0]   i_setupEndp,
  input  logic              i_ackValid,
  input  logic              i_ackTimeout,
  input  logic [N_ENDP-1:0] i_etValid,
  input  logic [N_ENDP-1:0] i_etStall,
  output logic [N_ENDP-1:0] o_etReady,
  output logic [EP_W-1:0]   o_txEndp,
  output logic [1:0]        o_txPid,
  output logic              o_txValid,
  input  logic              i_txReady,
  input  logic              i_txDone,
  output logic              o_busy
);

  localparam int unsigned EXT_W = 16;
  localparam int unsigned CMP_W = EP_W + 1;

  state_t            state, state_d;
  pid_t              pid_q, pid_d;
  logic [EP_W-1:0]   endp_q, endp_d;
  logic              valid_q, valid_d;
  logic              busy_q, busy_d;
  logic [N_ENDP-1:0] ready_q, ready_d;
  logic [N_ENDP-1:0] toggle;
  logic [EXT_W-1:0]  stall_ext, avail_ext, toggle_ext;
  logic              tok_ok, ack_fire, timeout;

  // Pad per-endpoint vectors so the 4-bit endpoint number indexes them directly.
  assign stall_ext  = EXT_W'(i_etStall);
  assign avail_ext  = EXT_W'(i_etValid);
  assign toggle_ext = EXT_W'(toggle);
  assign tok_ok     = i_tokValid && ({1'b0, i_tokEndp} < CMP_W'(N_ENDP));
  assign ack_fire   = (state == ST_WAIT_ACK) && i_ackValid;

`ifdef USBFS_IN_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(ACK_TIMEOUT + 1);
  logic [CNT_W-1:0] cnt;
  logic             unused_ack_timeout;

  assign unused_ack_timeout = i_ackTimeout;
  assign timeout            = (cnt == CNT_W'(ACK_TIMEOUT));

  always_ff @(posedge i_clk) begin
    if (!i_rstn || (state != ST_WAIT_ACK)) begin
      cnt <= '0;
    end else if (!timeout) begin
      cnt <= cnt + CNT_W'(1);
    end
  end
`else
  logic unused_cfg;

  assign unused_cfg = (ACK_TIMEOUT == 0);
  assign timeout    = i_ackTimeout;
`endif

  usbfs_toggle_bank #(
    .N_ENDP(N_ENDP)
  ) u_toggle_bank (
    .clk       (i_clk),
    .rst_n     (i_rstn),
    .ack       (ack_fire),
    .ack_endp  (endp_q),
    .setup     (i_setupValid),
    .setup_endp(i_setupEndp),
    .toggle    (toggle)
  );

  // Next state and next registered outputs.
  always_comb begin
    state_d = state;
    pid_d   = pid_q;
    endp_d  = endp_q;
    ready_d = '0;
    case (state)
      ST_IDLE: begin
        if (tok_ok) begin
          endp_d  = i_tokEndp;
          state_d = ST_REQ;
          if (stall_ext[i_tokEndp]) begin
            pid_d = PID_STALL;
          end else if (avail_ext[i_tokEndp]) begin
            pid_d = data_pid(toggle_ext[i_tokEndp]);
          end else begin
            pid_d = PID_NAK;
          end
        end
      end
      ST_REQ: begin
        if (valid_q && i_txReady) state_d = ST_TX;
      end
      ST_TX: begin
        if (i_txDone) begin
          state_d = ((pid_q == PID_DATA0) || (pid_q == PID_DATA1)) ? ST_WAIT_ACK : ST_IDLE;
        end
      end
      ST_WAIT_ACK: begin
        if (i_ackValid) begin
          state_d = ST_IDLE;
          for (int i = 0; i < int'(N_ENDP); i++) begin
            ready_d[i] = (endp_q == EP_W'(i));
          end
        end else if (timeout) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    valid_d = (state_d == ST_REQ);
    busy_d  = (state_d != ST_IDLE);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      state   <= ST_IDLE;
      pid_q   <= PID_DATA0;
      endp_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      ready_q <= '0;
    end else begin
      state   <= state_d;
      pid_q   <= pid_d;
      endp_q  <= endp_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      ready_q <= ready_d;
    end
  end

  assign o_etReady = ready_q;
  assign o_txEndp  = endp_q;
  assign o_txPid   = pid_q;
  assign o_txValid = valid_q;
  assign o_busy    = busy_q;

endmodule

// File: tb/tb_usbfs_in_arb.sv
// Directed bench for usbfs_in_arb (default build: external i_ackTimeout).
module tb_usbfs_in_arb;

  logic       clk;
  logic       rstn;
  logic       tok_valid;
  logic [3:0] tok_endp;
  logic       setup_valid;
  logic [3:0] setup_endp;
  logic       ack_valid;
  logic       ack_timeout;
  logic [3:0] et_valid;
  logic [3:0] et_stall;
  logic [3:0] et_ready;
  logic [3:0] tx_endp;
  logic [1:0] tx_pid;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx_done;
  logic       busy;

  int n_vec  = 0;
  int n_miss = 0;

  usbfs_in_arb #(
    .N_ENDP     (4),
    .ACK_TIMEOUT(18)
  ) dut (
    .i_clk       (clk),
    .i_rstn      (rstn),
    .i_tokValid  (tok_valid),
    .i_tokEndp   (tok_endp),
    .i_setupValid(setup_valid),
    .i_setupEndp (setup_endp),
    .i_ackValid  (ack_valid),
    .i_ackTimeout(ack_timeout),
    .i_etValid   (et_valid),
    .i_etStall   (et_stall),
    .o_etReady   (et_ready),
    .o_txEndp    (tx_endp),
    .o_txPid     (tx_pid),
    .o_txValid   (tx_valid),
    .i_txReady   (tx_ready),
    .i_txDone    (tx_done),
    .o_busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are then sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic token(input logic [3:0] e);
    tok_valid = 1'b1;
    tok_endp  = e;
    tick();
    tok_valid = 1'b0;
  endtask

  task automatic accept();
    tx_ready = 1'b1;
    tick();
    tx_ready = 1'b0;
  endtask

  task automatic done();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
  endtask

  task automatic ack();
    ack_valid = 1'b1;
    tick();
    ack_valid = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_valid"}, 32'(tx_valid), 32'd0);
    check({tag, "_ready"}, 32'(et_ready), 32'd0);
    check({tag, "_endp"},  32'(tx_endp),  32'd0);
    check({tag, "_pid"},   32'(tx_pid),   32'd0);
    check({tag, "_busy"},  32'(busy),     32'd0);
  endtask

  initial begin
    rstn = 1'b0; tok_valid = 1'b0; tok_endp = 4'd0; setup_valid = 1'b0; setup_endp = 4'd0;
    ack_valid = 1'b0; ack_timeout = 1'b0; et_valid = 4'b0000; et_stall = 4'b0000;
    tx_ready = 1'b0; tx_done = 1'b0;
    tick();
    tick();
    check_idle_outputs("rst");
    rstn = 1'b1;
    tick();

    // DATA0 on ep2, ACKed, then DATA1 on the retry
    et_valid = 4'b0100;
    token(4'd2);
    check("ep2_valid", 32'(tx_valid), 32'd1);
    check("ep2_pid",   32'(tx_pid),   32'd0);
    check("ep2_endp",  32'(tx_endp),  32'd2);
    check("ep2_busy",  32'(busy),     32'd1);
    tick();
    check("ep2_hold",  32'(tx_valid), 32'd1);
    accept();
    check("ep2_drop_valid", 32'(tx_valid), 32'd0);
    done();
    check("ep2_wait_busy",  32'(busy),     32'd1);
    check("ep2_wait_ready", 32'(et_ready), 32'd0);
    ack();
    check("ep2_ready", 32'(et_ready), 32'b0100);
    check("ep2_idle",  32'(busy),     32'd0);
    tick();
    check("ep2_ready_pulse", 32'(et_ready), 32'd0);
    token(4'd2);
    check("ep2_pid1", 32'(tx_pid), 32'd1);
    accept();
    done();
    ack();
    check("ep2_ready2", 32'(et_ready), 32'b0100);

    // NAK on ep1: no WAIT_ACK, stray ACK ignored
    et_valid = 4'b0000;
    token(4'd1);
    check("nak_pid",  32'(tx_pid),  32'd2);
    check("nak_endp", 32'(tx_endp), 32'd1);
    accept();
    done();
    check("nak_idle", 32'(busy), 32'd0);
    ack();
    check("nak_ready", 32'(et_ready), 32'd0);

    // STALL beats valid on ep3
    et_valid = 4'b1000;
    et_stall = 4'b1000;
    token(4'd3);
    check("stall_pid", 32'(tx_pid), 32'd3);
    et_stall = 4'b0000;
    accept();
    done();
    check("stall_idle", 32'(busy), 32'd0);
    ack();
    check("stall_ready", 32'(et_ready), 32'd0);

    // Out-of-range endpoint ignored
    token(4'd5);
    check("oor_valid", 32'(tx_valid), 32'd0);
    check("oor_busy",  32'(busy),     32'd0);

    // Timeout on ep0 leaves toggle alone; retry resends DATA0
    et_valid = 4'b0001;
    token(4'd0);
    check("to_pid", 32'(tx_pid), 32'd0);
    accept();
    done();
    ack_timeout = 1'b1;
    tick();
    ack_timeout = 1'b0;
    check("to_ready", 32'(et_ready), 32'd0);
    check("to_idle",  32'(busy),     32'd0);
    token(4'd0);
    check("retry_pid", 32'(tx_pid), 32'd0);
    accept();
    done();
    ack();
    check("retry_ready", 32'(et_ready), 32'b0001);

    // DATA1 on ep0; IN token during TX dropped; SETUP beats coincident ACK
    token(4'd0);
    check("d1_pid", 32'(tx_pid), 32'd1);
    accept();
    token(4'd2);
    check("drop_endp",  32'(tx_endp),  32'd0);
    check("drop_pid",   32'(tx_pid),   32'd1);
    check("drop_valid", 32'(tx_valid), 32'd0);
    done();
    check("drop_wait", 32'(busy), 32'd1);
    ack_valid   = 1'b1;
    setup_valid = 1'b1;
    setup_endp  = 4'd0;
    tick();
    ack_valid   = 1'b0;
    setup_valid = 1'b0;
    check("setup_ready", 32'(et_ready), 32'b0001);
    token(4'd0);
    check("setup_pid", 32'(tx_pid), 32'd1);
    accept();
    done();
    check("rst_wait_busy", 32'(busy), 32'd1);

    // Reset in WAIT_ACK abandons the packet and clears toggles
    rstn = 1'b0;
    tick();
    check_idle_outputs("midrst");
    rstn = 1'b1;
    ack();
    check("midrst_ack_ready", 32'(et_ready), 32'd0);
    check("midrst_ack_busy",  32'(busy),     32'd0);
    token(4'd0);
    check("midrst_pid", 32'(tx_pid), 32'd0);
    accept();
    done();
    ack();
    check("midrst_ready", 32'(et_ready), 32'b0001);

    // SETUP in idle on ep1 forces DATA1 there
    et_valid   = 4'b0010;
    setup_valid = 1'b1;
    setup_endp  = 4'd1;
    tick();
    setup_valid = 1'b0;
    token(4'd1);
    check("setup_idle_pid", 32'(tx_pid), 32'd1);
    accept();
    done();
    ack();
    check("setup_idle_ready", 32'(et_ready), 32'b0010);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
